// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS stopwatch counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] MAX_VAL = 16'h5959;
    localparam logic [15:0] MIN_VAL = 16'h0000;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/data bundle between the operation unit (master) and the stopwatch (slave).
interface stopwatch_counter_if;

    logic        TICK;
    logic        MODE;
    logic        SS;
    logic        LD;
    logic [15:0] I;
    logic [15:0] Q;
    logic        RUNNING;
    logic        DONE;
    logic        ERR;

    modport master (
        output TICK, MODE, SS, LD, I,
        input  Q, RUNNING, DONE, ERR
    );

    modport slave (
        input  TICK, MODE, SS, LD, I,
        output Q, RUNNING, DONE, ERR
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit of modulus MOD with load, increment/decrement and carry/borrow out.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       inc,
    input  logic       dec,
    output bcd_digit_t q,
    output logic       co,
    output logic       bo
);

    localparam bcd_digit_t TOP = bcd_digit_t'(MOD - 1);

    // Carry/borrow are combinational so a whole MM:SS ripple lands on one edge.
    assign co = inc && (q == TOP);
    assign bo = dec && (q == '0);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else if (inc)
            q <= co ? '0 : q + 4'd1;
        else if (dec)
            q <= bo ? TOP : q - 4'd1;
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS up/down stopwatch: BCD load validation, run/pause/done FSM and a 4-digit chain.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    stopwatch_counter_if.slave  bus
);

    // Values one step short of each limit; the step that lands on them ends the run.
    localparam logic [15:0] PRE_MAX = 16'h5958;
    localparam logic [15:0] PRE_MIN = 16'h0001;

    sw_state_t        state, state_nxt;
    bcd_digit_t [3:0] dig;
    logic [15:0]      q_cur;
    logic [4:0]       cy, bw;
    logic             load, cnt_up, cnt_dn, err_nxt;
    logic             running_q, done_q, err_q;
    logic             unused_chain;

    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) &&
               (v[11:8] <= 4'd9) && (v[15:12] <= 4'd5);
    endfunction

    assign q_cur = dig;
    assign cy[0] = cnt_up;
    assign bw[0] = cnt_dn;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_counter #(
            .MOD ((g % 2 == 0) ? 10 : 6)
        ) u_dig (
            .clk    (CLK),
            .rst    (RST),
            .ld     (load),
            .ld_val (bus.I[g*4 +: 4]),
            .inc    (cy[g]),
            .dec    (bw[g]),
            .q      (dig[g]),
            .co     (cy[g+1]),
            .bo     (bw[g+1])
        );
    end

    // The limit guard stops the chain before the top digit can wrap.
    assign unused_chain = &{1'b0, cy[4], bw[4]};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cnt_up    = 1'b0;
        cnt_dn    = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            ST_IDLE:  if (bus.SS) state_nxt = ST_RUN;
            ST_RUN:   if (bus.SS) state_nxt = ST_PAUSE;
            ST_PAUSE: if (bus.SS) state_nxt = ST_RUN;
            default:  ;
        endcase

        // A load always swallows a coincident tick, valid or not.
        if (bus.LD) begin
            if (bcd_ok(bus.I)) begin
                load = 1'b1;
                if (state == ST_DONE)
                    state_nxt = ST_PAUSE;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (state == ST_RUN && bus.TICK) begin
            if (bus.MODE) begin
                if (q_cur == MAX_VAL) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_up = 1'b1;
                    if (q_cur == PRE_MAX) state_nxt = ST_DONE;
                end
            end else begin
                if (q_cur == MIN_VAL) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_dn = 1'b1;
                    if (q_cur == PRE_MIN) state_nxt = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            running_q <= (state_nxt == ST_RUN);
            done_q    <= (state_nxt == ST_DONE);
            err_q     <= err_nxt;
        end
    end

    assign bus.Q       = q_cur;
    assign bus.RUNNING = running_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed vector table plus a long tick sequence for the stopwatch counter.
module tb_stopwatch_counter;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    stopwatch_counter_if bus ();

    stopwatch_counter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, tick, mode, ss, ld;
        logic [15:0] i;
        logic [15:0] q;
        logic        run, done, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, tick, mode, ss, ld,
                                input logic [15:0] i, q,
                                input logic run, done, err);
        vec_t v;
        v.rst = rst; v.tick = tick; v.mode = mode; v.ss = ss; v.ld = ld;
        v.i = i; v.q = q; v.run = run; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, tick, mode, ss, ld, input logic [15:0] i);
        RST      = rst;
        bus.TICK = tick;
        bus.MODE = mode;
        bus.SS   = ss;
        bus.LD   = ld;
        bus.I    = i;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] q,
                           input logic run, done, err);
        chk({tag, ".Q"},       bus.Q,              q);
        chk({tag, ".RUNNING"}, 16'(bus.RUNNING),   16'(run));
        chk({tag, ".DONE"},    16'(bus.DONE),      16'(done));
        chk({tag, ".ERR"},     16'(bus.ERR),       16'(err));
    endtask

    initial begin
        RST = 1'b1; bus.TICK = 0; bus.MODE = 1; bus.SS = 0; bus.LD = 0; bus.I = '0;

        //              rst tk md ss ld  I         Q        run dn er
        vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 0)); // IDLE->RUN
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0)); // three ticks
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0959, 16'h0959, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0)); // full carry ripple
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h1000, 0, 0, 0)); // RUN->PAUSE
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h1000, 0, 0, 0)); // tick ignored
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0001, 16'h0001, 1, 0, 0)); // LD+SS
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0)); // reach 00:00
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0)); // hold
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0)); // SS in DONE
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h5960, 16'h0000, 0, 1, 1)); // invalid load
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0)); // ERR one cycle
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 0)); // DONE->PAUSE
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0)); // borrow
        vecs.push_back(mk(0, 1, 1, 0, 1, 16'h1200, 16'h1200, 1, 0, 0)); // LD+TICK
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h1201, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h5958, 16'h5958, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h5959, 0, 1, 0)); // reach 59:59
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h5959, 16'h5959, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h5959, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h5959, 0, 1, 0)); // already at limit
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0042, 16'h0042, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h0042, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0, 0)); // reset wins
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0)); // IDLE ignores tick
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0A00, 16'h0000, 0, 0, 1)); // bad min units
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h9000, 16'h0000, 0, 0, 1)); // bad min tens
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0059, 16'h0059, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h0059, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0100, 1, 0, 0)); // sec tens carry
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h1000, 16'h1000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0959, 1, 0, 0)); // min tens borrow

        @(negedge CLK);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].tick, vecs[k].mode, vecs[k].ss, vecs[k].ld, vecs[k].i);
            chk_all($sformatf("vec%0d", k), vecs[k].q, vecs[k].run, vecs[k].done, vecs[k].err);
        end

        // 61 spaced ticks from 00:00 end at 01:01.
        drive(1, 0, 1, 0, 0, 16'h0000);
        drive(0, 0, 1, 1, 0, 16'h0000);
        for (int n = 0; n < 61; n++) begin
            drive(0, 1, 1, 0, 0, 16'h0000);
            drive(0, 0, 1, 0, 0, 16'h0000);
        end
        chk_all("seq61", 16'h0101, 1, 0, 0);

        // MODE change alone is inert; the next two ticks count down.
        drive(0, 0, 0, 0, 0, 16'h0000);
        chk_all("mode_only", 16'h0101, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0000);
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_all("seq_down", 16'h0059, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
